urv_dm_responder: RTL and testbench
===================================

// Module: urv_dm_responder
// PURPOSE
//  Synthesizable responder for the uRV data-memory interface: services CPU loads/stores with
//  byte-lane writes into an on-chip word RAM and a memory-mapped byte output port.
//  Sits between urv_cpu dm_* pins and the SoC. Output bytes are queued in a TX FIFO and
//  drained by a valid/ready consumer, e.g. a UART transmitter.
// PARAMETERS
//  MEM_WORDS    16384  RAM depth in 32-bit words (power of two)
//  ADDR_BITS    16     byte-address bits decoded for RAM (log2(MEM_WORDS)+2)
//  FIFO_DEPTH   4      TX FIFO entries (power of two, >=2)
//  WAIT_CYCLES  2      extra RAM load latency when URV_DM_WAIT_STATES_EN is defined (>=1)
// PORTS
//  clk_i              in   1   clock, all logic on rising edge
//  rst_i              in   1   reset, asynchronous, active-high
//  dm_addr_i          in   32  byte address from CPU
//  dm_data_s_i        in   32  store data
//  dm_data_select_i   in   4   byte-lane enables, bit n = data[8n+7:8n]
//  dm_store_i         in   1   store request
//  dm_load_i          in   1   load request
//  dm_data_l_o        out  32  load data, valid when dm_load_done_o=1
//  dm_load_done_o     out  1   one-cycle load completion pulse
//  dm_store_done_o    out  1   one-cycle store completion pulse
//  dm_ready_o         out  1   responder can accept a request this cycle
//  io_data_o          out  8   FIFO head byte
//  io_valid_o         out  1   FIFO non-empty
//  io_ready_i         in   1   consumer takes io_data_o when io_valid_o&io_ready_i
// BEHAVIOUR
//  - Map: RAM when addr[31:16]==0; TXDATA at 0x0001_0000 (W); STATUS at 0x0001_0004 (R);
//    all other addresses unmapped.
//  - Accept: request accepted on a cycle with (dm_load_i|dm_store_i)&dm_ready_o. The initiator
//    holds the address, data, select and strobe stable while dm_ready_o=0.
//    Load and store asserted together: the store is taken and the load is ignored.
//  - FSM states: IDLE, WAIT, RESP. IDLE->RESP on accept. RESP outputs a done pulse and
//    returns to IDLE. dm_ready_o=1 only in IDLE.
//  - Latency: done pulse and dm_data_l_o arrive exactly 1 cycle after accept. Back-to-back
//    throughput is 1 request per 2 cycles.
//  - RAM store: lanes with select bit set are written at accept. Other lanes are unchanged.
//    Word index = addr[ADDR_BITS-1:2]. addr[1:0] is ignored.
//  - RAM load: full word at addr[ADDR_BITS-1:2]. A load of the word stored in the previous
//    request returns the new data.
//  - TXDATA store: pushes dm_data_s_i[7:0], regardless of the select bits.
//    If the FIFO is full, stay in IDLE with dm_ready_o=0 until space frees, then accept.
//  - Simultaneous push and pop on a full FIFO is legal: occupancy is unchanged.
//  - STATUS load: {16'b0, 8'(level), 6'b0, full, empty}. A store to STATUS is ignored but done.
//  - Unmapped: load returns 32'h0, store is dropped, and done is still pulsed.
//  - FIFO: pointers wrap modulo FIFO_DEPTH. level counts 0..FIFO_DEPTH.
//    io_valid_o is combinational from !empty. The pop is independent of the dm side.
//  - Reset values: dm_data_l_o=0, both dones 0, dm_ready_o=1, FSM=IDLE, FIFO empty,
//    io_valid_o=0, io_data_o=0. RAM contents are not reset.
//  - Reset mid-transaction: the pending response is dropped with no done pulse.
//    A partially written RAM word keeps the lanes already written.
// CONFIGURATION
//  URV_DM_WAIT_STATES_EN defined:
//    - A RAM load goes IDLE->WAIT for WAIT_CYCLES cycles, then RESP.
//    - Load latency = WAIT_CYCLES+1.
//    - IO, STATUS, unmapped and store paths are unaffected (latency 1).
//  URV_DM_WAIT_STATES_EN undefined:
//    - The WAIT state and its counter are not built. All latencies are 1.
// STRUCTURE
//  - Package urv_dm_pkg:
//    - address constants: RAM_BASE, TXDATA_ADDR, STATUS_ADDR
//    - region enum: REG_RAM, REG_TX, REG_STAT, REG_NONE
//    - FSM state enum
//  - Sub-module urv_dm_txfifo: byte FIFO with push/full and pop/empty/level.
//  - The RAM is an inferred array with byte-enable write in this module.
// TESTING
//  1. Reset, then store 0xDEADBEEF sel=4'hF to 0x0000_0010, then load 0x10
//     -> store_done 1 cycle after accept, load_done with 0xDEADBEEF 1 cycle after accept.
//  2. Store 0x000000AA sel=4'b0001 to 0x10, then load 0x10
//     -> 0xDEADBEAA, showing that unselected lanes are preserved.
//  3. io_ready_i=0; store 0x41,0x42,0x43,0x44,0x45 to 0x0001_0000
//     -> the first 4 complete, the 5th stalls with dm_ready_o=0.
//     Raise io_ready_i -> bytes are seen in order 41..45 and the 5th store_done follows the first pop.
//  4. Load 0x0001_0004 with 3 bytes queued -> 0x0000_0300.
//     Load it with the FIFO empty -> 0x0000_0001.
//  5. Load 0x0002_0000 -> 0x00000000 with load_done. Store there -> store_done and no RAM change.
//  6. Assert rst_i during RESP -> no done pulse, all outputs at reset values.
//     With URV_DM_WAIT_STATES_EN and WAIT_CYCLES=2, a RAM load completes 3 cycles after accept.

Source files
------------

// File: rtl/urv_dm_pkg.sv
// ============================================================================
//  Module      : urv_dm_pkg
//  Description : Shared address map, region and FSM state types for the uRV
//                data-memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package urv_dm_pkg;

    // Memory map
    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] TXDATA_ADDR = 32'h0001_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h0001_0004;

    // Address region of a request
    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_TX   = 2'd1,
        REG_STAT = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Responder FSM state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // RAM occupies the whole lower 64 KiB window; the two IO registers are
    // exact-match decodes, everything else is unmapped.
    function automatic region_e decode_region(input logic [31:0] addr);
        region_e r;
        if (addr[31:16] == RAM_BASE[31:16]) begin
            r = REG_RAM;
        end else if (addr == TXDATA_ADDR) begin
            r = REG_TX;
        end else if (addr == STATUS_ADDR) begin
            r = REG_STAT;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/urv_dm_txfifo.sv
// ============================================================================
//  Module      : urv_dm_txfifo
//  Description : Byte FIFO for the memory-mapped output port. Head byte is
//                presented combinationally and reads as zero when empty.
//                A push on a full FIFO is taken only when a pop happens in
//                the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module urv_dm_txfifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int LVL_BITS = PTR_BITS + 1;

    logic [7:0]          mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [LVL_BITS-1:0] level_q;

    logic full_w;
    logic empty_w;
    logic do_push_w;
    logic do_pop_w;

    assign full_w    = (level_q == LVL_BITS'(DEPTH));
    assign empty_w   = (level_q == '0);
    assign do_pop_w  = pop_i && !empty_w;
    assign do_push_w = push_i && (!full_w || do_pop_w);

    // Storage is not reset; the head byte is masked while empty instead.
    always_ff @(posedge clk_i) begin
        if (do_push_w) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push_w) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (do_pop_w) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            case ({do_push_w, do_pop_w})
                2'b10:   level_q <= level_q + LVL_BITS'(1);
                2'b01:   level_q <= level_q - LVL_BITS'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign full_o  = full_w;
    assign empty_o = empty_w;
    assign level_o = level_q;
    assign data_o  = empty_w ? 8'h00 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/urv_dm_responder.sv
// ============================================================================
//  Module      : urv_dm_responder
//  Description : uRV data-memory responder. Byte-lane RAM, TXDATA byte port
//                backed by a FIFO, and a STATUS register. One request per two
//                cycles, response one cycle after accept.
//                Build option URV_DM_WAIT_STATES_EN adds WAIT_CYCLES extra
//                cycles of latency to RAM loads only.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module urv_dm_responder
    import urv_dm_pkg::*;
#(
    parameter int MEM_WORDS   = 16384,
    parameter int ADDR_BITS   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_ready_o,
    output logic [7:0]  io_data_o,
    output logic        io_valid_o,
    input  logic        io_ready_i
);

    localparam int IDX_BITS = ADDR_BITS - 2;
    localparam int LVL_BITS = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]         mem_q [MEM_WORDS];

    state_e              state_q;
    logic                load_done_q;
    logic                store_done_q;
    logic [31:0]         data_l_q;

    region_e             region_w;
    logic [IDX_BITS-1:0] idx_w;
    logic                tx_stall_w;
    logic                ready_w;
    logic                accept_w;
    logic                push_w;
    logic                pop_w;
    logic                ram_we_w;
    logic                fifo_full_w;
    logic                fifo_empty_w;
    logic [LVL_BITS-1:0] fifo_level_w;
    logic [7:0]          fifo_head_w;
    logic [31:0]         status_w;
    logic [31:0]         load_data_w;

`ifdef URV_DM_WAIT_STATES_EN
    localparam int CNT_BITS = $clog2(WAIT_CYCLES + 1);
    logic [CNT_BITS-1:0] wait_cnt_q;
    logic [IDX_BITS-1:0] wait_idx_q;
`endif

    assign region_w   = decode_region(dm_addr_i);
    assign idx_w      = dm_addr_i[ADDR_BITS-1:2];

    // A TXDATA store facing a full FIFO is held off; store wins over load.
    assign tx_stall_w = dm_store_i && (region_w == REG_TX) && fifo_full_w;
    assign ready_w    = (state_q == ST_IDLE) && !tx_stall_w;
    assign accept_w   = (dm_load_i || dm_store_i) && ready_w;
    assign push_w     = accept_w && dm_store_i && (region_w == REG_TX);
    assign ram_we_w   = accept_w && dm_store_i && (region_w == REG_RAM);
    assign pop_w      = !fifo_empty_w && io_ready_i;

    assign status_w   = {16'h0000, 8'(fifo_level_w), 6'b000000, fifo_full_w, fifo_empty_w};

    // Load result selected by region at accept time.
    always_comb begin
        load_data_w = 32'h0000_0000;
        case (region_w)
            REG_RAM:  load_data_w = mem_q[idx_w];
            REG_STAT: load_data_w = status_w;
            default:  load_data_w = 32'h0000_0000;
        endcase
    end

    // Byte-lane RAM write; unselected lanes keep their contents.
    always_ff @(posedge clk_i) begin
        if (ram_we_w) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_data_select_i[b]) begin
                    mem_q[idx_w][8*b +: 8] <= dm_data_s_i[8*b +: 8];
                end
            end
        end
    end

    // Request FSM with registered done pulses and load data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            data_l_q     <= 32'h0000_0000;
`ifdef URV_DM_WAIT_STATES_EN
            wait_cnt_q   <= '0;
            wait_idx_q   <= '0;
`endif
        end else begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_w) begin
                        if (dm_store_i) begin
                            store_done_q <= 1'b1;
                            state_q      <= ST_RESP;
`ifdef URV_DM_WAIT_STATES_EN
                        end else if (region_w == REG_RAM) begin
                            // Address may change after accept, so keep the index.
                            wait_cnt_q   <= CNT_BITS'(WAIT_CYCLES - 1);
                            wait_idx_q   <= idx_w;
                            state_q      <= ST_WAIT;
`endif
                        end else begin
                            data_l_q     <= load_data_w;
                            load_done_q  <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end
                end
`ifdef URV_DM_WAIT_STATES_EN
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        data_l_q    <= mem_q[wait_idx_q];
                        load_done_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q - CNT_BITS'(1);
                    end
                end
`endif
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    urv_dm_txfifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_txfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_w),
        .data_i  (dm_data_s_i[7:0]),
        .full_o  (fifo_full_w),
        .pop_i   (pop_w),
        .data_o  (fifo_head_w),
        .empty_o (fifo_empty_w),
        .level_o (fifo_level_w)
    );

    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_ready_o      = ready_w;
    assign io_data_o       = fifo_head_w;
    assign io_valid_o      = !fifo_empty_w;

endmodule

`default_nettype wire

// File: tb/tb_urv_dm_responder.sv
// ============================================================================
//  Module      : tb_urv_dm_responder
//  Description : Scoreboard bench for urv_dm_responder. A reference model of
//                the memory map (RAM words, byte queue) predicts each
//                response at accept; a monitor pops and compares on done.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_urv_dm_responder;

    localparam int FIFO_DEPTH  = 4;
    localparam int WAIT_CYCLES = 2;
`ifdef URV_DM_WAIT_STATES_EN
    localparam int RAM_LOAD_LAT = WAIT_CYCLES + 1;
`else
    localparam int RAM_LOAD_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] dm_addr_i = 32'h0;
    logic [31:0] dm_data_s_i = 32'h0;
    logic [3:0]  dm_data_select_i = 4'h0;
    logic        dm_store_i = 1'b0;
    logic        dm_load_i = 1'b0;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        dm_ready_o;
    logic [7:0]  io_data_o;
    logic        io_valid_o;
    logic        io_ready_i = 1'b0;

    urv_dm_responder #(
        .MEM_WORDS   (16384),
        .ADDR_BITS   (16),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_store_i       (dm_store_i),
        .dm_load_i        (dm_load_i),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_store_done_o  (dm_store_done_o),
        .dm_ready_o       (dm_ready_o),
        .io_data_o        (io_data_o),
        .io_valid_o       (io_valid_o),
        .io_ready_i       (io_ready_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rand_io = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  fifo_m[$];
    logic [31:0] ram_m [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reset discards every pending response and empties the byte queue.
    always @(posedge rst_i) begin
        exp_q.delete();
        fifo_m.delete();
    end

    // Reference model: byte port handshake, then request accept.
    exp_t        m_e;
    int          m_size;
    int          m_idx;
    logic [31:0] m_word;
    always @(negedge clk) begin
        if (!rst_i) begin
            m_size = fifo_m.size();
            check("io_valid", {31'b0, io_valid_o}, {31'b0, (m_size != 0)});
            if (io_valid_o && io_ready_i && fifo_m.size() > 0) begin
                check("io_data", {24'b0, io_data_o}, {24'b0, fifo_m.pop_front()});
            end
            if ((dm_load_i || dm_store_i) && dm_ready_o) begin
                m_e.acc_cyc = cyc;
                m_e.lat     = 1;
                m_e.data    = 32'h0;
                m_idx       = int'(dm_addr_i[15:2]);
                if (dm_store_i) begin
                    m_e.is_load = 1'b0;
                    if (dm_addr_i[31:16] == 16'h0) begin
                        m_word = ram_m.exists(m_idx) ? ram_m[m_idx] : 32'hxxxx_xxxx;
                        for (int b = 0; b < 4; b++)
                            if (dm_data_select_i[b]) m_word[8*b +: 8] = dm_data_s_i[8*b +: 8];
                        ram_m[m_idx] = m_word;
                    end else if (dm_addr_i == 32'h0001_0000) begin
                        check("tx_accept_not_full", {31'b0, (m_size < FIFO_DEPTH)}, 32'h1);
                        fifo_m.push_back(dm_data_s_i[7:0]);
                    end
                end else begin
                    m_e.is_load = 1'b1;
                    if (dm_addr_i[31:16] == 16'h0) begin
                        m_e.data = ram_m.exists(m_idx) ? ram_m[m_idx] : 32'hxxxx_xxxx;
                        m_e.lat  = RAM_LOAD_LAT;
                    end else if (dm_addr_i == 32'h0001_0004) begin
                        m_e.data = {16'h0, 8'(m_size), 6'h0, (m_size == FIFO_DEPTH), (m_size == 0)};
                    end
                end
                exp_q.push_back(m_e);
            end
        end
    end

    // Monitor: every done pulse retires the oldest expected response.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_i && (dm_load_done_o || dm_store_done_o)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got load=%0b store=%0b expected none", dm_load_done_o, dm_store_done_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_kind", {31'b0, dm_load_done_o}, {31'b0, mon_e.is_load});
                check("done_exclusive", {31'b0, dm_load_done_o & dm_store_done_o}, 32'h0);
                check("latency", cyc - mon_e.acc_cyc, mon_e.lat);
                if (mon_e.is_load) check("load_data", dm_data_l_o, mon_e.data);
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    always @(posedge clk) begin
        if (rand_io) begin
            #1 io_ready_i = ($urandom_range(0, 1) == 1);
        end
    end

    // All driver tasks start and return at posedge+1.
    task automatic drive(input bit ld, input bit st, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] sel);
        dm_load_i        = ld;
        dm_store_i       = st;
        dm_addr_i        = a;
        dm_data_s_i      = d;
        dm_data_select_i = sel;
    endtask

    task automatic wait_accept();
        int w = 0;
        @(negedge clk);
        while (!dm_ready_o && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!dm_ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        dm_load_i  = 1'b0;
        dm_store_i = 1'b0;
    endtask

    task automatic req(input bit ld, input bit st, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sel);
        drive(ld, st, a, d, sel);
        wait_accept();
    endtask

    task automatic wait_empty();
        int w = 0;
        while (io_valid_o && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (io_valid_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got io_valid=1 expected 0");
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_l"},     dm_data_l_o, 32'h0);
        check({tag, "_load_done"},  {31'b0, dm_load_done_o}, 32'h0);
        check({tag, "_store_done"}, {31'b0, dm_store_done_o}, 32'h0);
        check({tag, "_ready"},      {31'b0, dm_ready_o}, 32'h1);
        check({tag, "_io_valid"},   {31'b0, io_valid_o}, 32'h0);
        check({tag, "_io_data"},    {24'b0, io_data_o}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] r_addr;
    logic [31:0] r_data;
    int          r_sel;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Full-word store, then load back
        req(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        req(1, 0, 32'h0000_0010, 32'h0, 4'h0);

        // Single-lane store keeps other lanes
        req(0, 1, 32'h0000_0010, 32'h0000_00AA, 4'b0001);
        req(1, 0, 32'h0000_0010, 32'h0, 4'h0);

        // Fill the byte port; fifth store must stall until a pop
        io_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) req(0, 1, 32'h0001_0000, 32'h41 + i, 4'h0);
        drive(0, 1, 32'h0001_0000, 32'h45, 4'h0);
        repeat (3) begin
            @(negedge clk);
            check("tx_full_stall", {31'b0, dm_ready_o}, 32'h0);
        end
        io_ready_i = 1'b1;
        wait_accept();
        wait_empty();

        // STATUS with three bytes queued and with the FIFO empty
        io_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) req(0, 1, 32'h0001_0000, 32'h60 + i, 4'hF);
        req(1, 0, 32'h0001_0004, 32'h0, 4'h0);
        io_ready_i = 1'b1;
        wait_empty();
        req(1, 0, 32'h0001_0004, 32'h0, 4'h0);
        req(0, 1, 32'h0001_0004, 32'hFFFF_FFFF, 4'hF);

        // Unmapped accesses: zero load, dropped store
        req(0, 1, 32'h0000_0000, 32'h1234_5678, 4'hF);
        req(1, 0, 32'h0002_0000, 32'h0, 4'h0);
        req(0, 1, 32'h0002_0000, 32'hFFFF_FFFF, 4'hF);
        req(1, 0, 32'h0000_0000, 32'h0, 4'h0);

        // Random phase over a small initialised RAM window
        for (int k = 0; k < 8; k++) req(0, 1, 32'h100 + 4 * k, $urandom, 4'hF);
        rand_io = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r_data = $urandom;
            r_sel  = $urandom_range(0, 15);
            r_addr = 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: req(0, 1, r_addr, r_data, r_sel[3:0]);
                4, 5:       req(1, 0, r_addr, r_data, r_sel[3:0]);
                6:          req(0, 1, 32'h0001_0000, r_data, r_sel[3:0]);
                7:          req(1, 0, 32'h0001_0004, r_data, r_sel[3:0]);
                8:          req($urandom_range(0, 1) == 1, 1'b0,
                                {16'($urandom_range(2, 16'hFFFF)), 16'($urandom)}, r_data, r_sel[3:0]);
                default:    req(1, 1, r_addr, r_data, r_sel[3:0]);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_io = 1'b0;
        @(posedge clk);
        #1 io_ready_i = 1'b1;
        wait_empty();
        repeat (WAIT_CYCLES + 3) @(posedge clk);
        #1;

        // Reset while a store response is pending
        io_ready_i = 1'b0;
        req(0, 1, 32'h0001_0000, 32'h77, 4'hF);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk);
        #1 rst_i = 1'b0;
        req(1, 0, 32'h0000_0010, 32'h0, 4'h0);
        req(1, 0, 32'h0001_0004, 32'h0, 4'h0);

        // All expected responses retired
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
